// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary for the LEGv8 pipeline: write-back bypass into decode,
// load-use bubble insertion, and the ID/EX register with hold and flush.
module id_ex_stage #(
    parameter int CTRL_W       = 16,
    parameter int MEMREAD_BIT  = 3,
    parameter int REGWRITE_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_Rn,
    input  logic [4:0]        id_Rm,
    input  logic [4:0]        id_Rd,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [63:0]       id_ReadData1,
    input  logic [63:0]       id_ReadData2,
    input  logic [63:0]       id_Imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_RegWrite,
    input  logic [4:0]        wb_Rd,
    input  logic [63:0]       wb_Data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [63:0]       ex_A,
    output logic [63:0]       ex_B,
    output logic [63:0]       ex_Imm,
    output logic [4:0]        ex_Rn,
    output logic [4:0]        ex_Rm,
    output logic [4:0]        ex_Rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              load_use_stall
);

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic              valid;
        logic [63:0]       a;
        logic [63:0]       b;
        logic [63:0]       imm;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

    idex_t ex_q;
    idex_t ex_d;
    idex_t bubble;
    idex_t capture;

    // Index 0 is the Rn / ReadData1 path, index 1 is the Rm / ReadData2 path.
    logic [4:0]  src_num [2];
    logic        src_use [2];
    logic [63:0] src_rf  [2];
    logic [63:0] byp     [2];
    logic        src_hit [2];

    assign src_num[0] = id_Rn;
    assign src_num[1] = id_Rm;
    assign src_use[0] = id_uses_rn;
    assign src_use[1] = id_uses_rm;
    assign src_rf[0]  = id_ReadData1;
    assign src_rf[1]  = id_ReadData2;

    // The register file writes on the same edge that captures its read data, so
    // the write-back value is forwarded here; XZR always reads as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign byp[gi] = (src_num[gi] == XZR) ? 64'd0 :
                             (wb_RegWrite && (wb_Rd != XZR) && (wb_Rd == src_num[gi])) ? wb_Data :
                             src_rf[gi];
            assign src_hit[gi] = src_use[gi] && (src_num[gi] == ex_q.rd);
        end
    endgenerate

    assign load_use_stall = !ex_hold && id_valid && ex_q.valid &&
                            ex_q.ctrl[MEMREAD_BIT] && (ex_q.rd != XZR) &&
                            (src_hit[0] || src_hit[1]);

    always_comb begin
        bubble       = '0;
        bubble.rn    = XZR;
        bubble.rm    = XZR;
        bubble.rd    = XZR;

        capture       = '0;
        capture.valid = id_valid;
        capture.a     = byp[0];
        capture.b     = byp[1];
        capture.imm   = id_Imm;
        capture.rn    = id_Rn;
        capture.rm    = id_Rm;
        capture.rd    = id_Rd;
        capture.ctrl  = id_valid ? id_ctrl : '0;
    end

    // A flush beats a hold: a squashed slot must never be retained.
    always_comb begin
        ex_d = capture;
        if (flush) begin
            ex_d = bubble;
        end else if (ex_hold) begin
            ex_d = ex_q;
        end else if (load_use_stall) begin
            ex_d = bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid = ex_q.valid;
    assign ex_A     = ex_q.a;
    assign ex_B     = ex_q.b;
    assign ex_Imm   = ex_q.imm;
    assign ex_Rn    = ex_q.rn;
    assign ex_Rm    = ex_q.rm;
    assign ex_Rd    = ex_q.rd;
    assign ex_ctrl  = ex_q.ctrl;

    // RegWrite is consumed further down the pipe, not in this stage.
    logic unused_regwrite;
    assign unused_regwrite = ex_q.ctrl[REGWRITE_BIT];

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute boundary of the pipelined LEGv8 CPU. It sits directly downstream of the register file and consumes its ReadData1/ReadData2.
- Applies write-back-to-decode bypass, because the register file writes at the same clock edge its outputs are sampled.
- Detects load-use hazards and inserts a bubble when one occurs.
- Registers operands, immediate, register numbers and control into the ID/EX pipeline register, with hold and flush.

Parameters:
CTRL_W, 16, width of the packed control bundle passed from decode to EX.
MEMREAD_BIT, 3, index of the MemRead bit inside the control bundle.
REGWRITE_BIT, 0, index of the RegWrite bit inside the control bundle.

Ports:
clk  input  1  pipeline clock, all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
id_valid  input  1  decode slot holds a real instruction.
id_Rn  input  5  first source register number.
id_Rm  input  5  second source register number.
id_Rd  input  5  destination register number.
id_uses_rn  input  1  instruction reads Rn.
id_uses_rm  input  1  instruction reads Rm (covers STUR/CBZ reading Rd via the Rm port).
id_ReadData1  input  64  register file read port 1.
id_ReadData2  input  64  register file read port 2.
id_Imm  input  64  sign/zero-extended immediate.
id_ctrl  input  CTRL_W  decoded control bundle.
wb_RegWrite  input  1  write-back stage is writing the register file this cycle.
wb_Rd  input  5  write-back destination register.
wb_Data  input  64  write-back data.
ex_hold  input  1  downstream stall; freeze the ID/EX register.
flush  input  1  branch-taken squash of the decode slot.
ex_valid  output  1  EX slot holds a real instruction.
ex_A  output  64  registered operand A.
ex_B  output  64  registered operand B.
ex_Imm  output  64  registered immediate.
ex_Rn  output  5  registered Rn.
ex_Rm  output  5  registered Rm.
ex_Rd  output  5  registered Rd.
ex_ctrl  output  CTRL_W  registered control bundle.
load_use_stall  output  1  combinational; upstream must hold the PC and IF/ID on this.

Behaviour:
- Reset: at the reset clock edge, ex_valid=0, ex_A=ex_B=ex_Imm=0, ex_ctrl=0, and ex_Rn=ex_Rm=ex_Rd=31. Register 31 never matches a forward compare.
- Bypass (combinational):
  - byp_A = 0 if id_Rn==31.
  - Otherwise byp_A = wb_Data if wb_RegWrite && wb_Rd!=31 && wb_Rd==id_Rn.
  - Otherwise byp_A = id_ReadData1.
  - byp_B uses the same rule with id_Rm and id_ReadData2.
- Load-use detect (combinational): load_use_stall=1 iff all of the following hold:
  - id_valid and ex_valid;
  - ex_ctrl[MEMREAD_BIT];
  - ex_Rd!=31;
  - (id_uses_rn && id_Rn==ex_Rd) || (id_uses_rm && id_Rm==ex_Rd).
- load_use_stall is forced to 0 while ex_hold=1, because the EX instruction is itself frozen and the upstream hold covers the stall.
- Per-edge update, in priority order:
  1. reset: load reset values.
  2. flush: bubble.
  3. ex_hold: all ex_* keep their value.
  4. load_use_stall: bubble.
  5. Otherwise: ex_valid<=id_valid, ex_A<=byp_A, ex_B<=byp_B, ex_Imm<=id_Imm, ex_Rn/Rm/Rd<=id_*, ex_ctrl<=id_valid ? id_ctrl : 0.
- Bubble: ex_valid=0, ex_ctrl=0, ex_Rn/Rm/Rd=31, ex_A/B/Imm=0. A bubble never writes the register file or memory downstream.
- flush overrides ex_hold: a squashed slot is never retained.
- Latency: exactly one cycle from ID inputs to ex_* outputs. Bypass and hazard outputs have zero latency.
- Stall lasts exactly one cycle per load: after the bubble the load has left EX, and its result reaches decode through EX/MEM forwarding or the WB bypass.
- Reset mid-stall: load_use_stall falls to 0 in the cycle after reset, since ex_valid=0.
- Gate delays on primitives follow the team's #delay gate-level style. Synthesizable with all delays stripped.

Test Plan:
- Reset, then issue ADD X1,X2,X3 with ReadData1=5, ReadData2=7, id_valid=1 -> next cycle ex_valid=1, ex_A=5, ex_B=7, ex_Rd=1, ex_ctrl=id_ctrl.
- WB bypass: id_Rn=4, id_ReadData1=0xAA, wb_RegWrite=1, wb_Rd=4, wb_Data=0x1234 -> ex_A=0x1234.
  - Repeat with wb_Rd=31 -> ex_A=0xAA.
  - Repeat with id_Rn=31 -> ex_A=0.
- Load-use: LDUR X9 in EX (MemRead=1, ex_Rd=9), ID has id_Rm=9 and id_uses_rm=1 -> load_use_stall=1 the same cycle, next cycle ex_valid=0 and ex_ctrl=0. The following cycle, with ID unchanged, stall=0 and the instruction is captured.
  - Same case with id_uses_rm=0 -> no stall.
- Hold: ex_hold=1 for 3 cycles while ID inputs change -> ex_* unchanged and load_use_stall=0 throughout. On release, the current ID inputs are captured.
- Flush with ex_hold=1 and load_use_stall conditions true -> next cycle bubble (ex_valid=0, ex_Rd=31).
- Reset asserted while a load-use stall is pending -> next cycle all outputs at reset values and load_use_stall=0.
